// File: rtl/base_ram_sched.sv
`default_nettype none
// ============================================================================
// Module   : base_ram_sched
// Function : Shares the single BaseRAM SRAM port between IFU and LSU with a
//            fixed multi-cycle access and a one-cycle response pulse.
// Revision : 1.0 - initial release
// ============================================================================
module base_ram_sched #(
    parameter int WAIT_CYCLES  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] ifu_addr_i,
    input  logic        ifu_req_i,
    output logic        ifu_resp_o,
    output logic [31:0] ifu_rdata_o,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_wdata_i,
    input  logic [3:0]  lsu_be_n_i,
    input  logic        lsu_we_n_i,
    input  logic        lsu_req_i,
    output logic        lsu_resp_o,
    output logic [31:0] lsu_rdata_o,
    output logic [19:0] ram_addr_o,
    output logic [31:0] ram_wdata_o,
    input  logic [31:0] ram_rdata_i,
    output logic [3:0]  ram_be_n_o,
    output logic        ram_ce_n_o,
    output logic        ram_oe_n_o,
    output logic        ram_we_n_o,
    output logic        busy_o
);

    localparam int c_CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam int c_STV_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_CNT_W-1:0] c_WAIT       = c_CNT_W'(WAIT_CYCLES);
    localparam logic [c_STV_W-1:0] c_STARVE_MAX = c_STV_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    state_e             state_q,     state_d;
    logic [c_CNT_W-1:0] cnt_q,       cnt_d;
    logic [c_STV_W-1:0] starve_q,    starve_d;
    logic               sel_lsu_q,   sel_lsu_d;
    logic               write_q,     write_d;
    logic [19:0]        ram_addr_q,  ram_addr_d;
    logic [31:0]        ram_wdata_q, ram_wdata_d;
    logic [3:0]         ram_be_n_q,  ram_be_n_d;
    logic               ram_ce_n_q,  ram_ce_n_d;
    logic               ram_oe_n_q,  ram_oe_n_d;
    logic               ram_we_n_q,  ram_we_n_d;
    logic               ifu_resp_q,  ifu_resp_d;
    logic               lsu_resp_q,  lsu_resp_d;
    logic [31:0]        ifu_rdata_q, ifu_rdata_d;
    logic [31:0]        lsu_rdata_q, lsu_rdata_d;

    logic w_grant_lsu;
    logic w_unused;

    // Address bits outside [21:2] are decoded upstream.
    assign w_unused = ^{ifu_addr_i[31:22], ifu_addr_i[1:0], lsu_addr_i[31:22], lsu_addr_i[1:0]};

    // LSU wins ties unless the IFU has already waited through STARVE_LIMIT LSU grants.
    assign w_grant_lsu = lsu_req_i && !(ifu_req_i && (starve_q == c_STARVE_MAX));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            starve_q    <= '0;
            sel_lsu_q   <= 1'b0;
            write_q     <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_be_n_q  <= 4'hF;
            ram_ce_n_q  <= 1'b1;
            ram_oe_n_q  <= 1'b1;
            ram_we_n_q  <= 1'b1;
            ifu_resp_q  <= 1'b0;
            lsu_resp_q  <= 1'b0;
            ifu_rdata_q <= '0;
            lsu_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            starve_q    <= starve_d;
            sel_lsu_q   <= sel_lsu_d;
            write_q     <= write_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ram_be_n_q  <= ram_be_n_d;
            ram_ce_n_q  <= ram_ce_n_d;
            ram_oe_n_q  <= ram_oe_n_d;
            ram_we_n_q  <= ram_we_n_d;
            ifu_resp_q  <= ifu_resp_d;
            lsu_resp_q  <= lsu_resp_d;
            ifu_rdata_q <= ifu_rdata_d;
            lsu_rdata_q <= lsu_rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        starve_d    = starve_q;
        sel_lsu_d   = sel_lsu_q;
        write_d     = write_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        ram_be_n_d  = ram_be_n_q;
        ram_ce_n_d  = ram_ce_n_q;
        ram_oe_n_d  = ram_oe_n_q;
        ram_we_n_d  = ram_we_n_q;
        ifu_resp_d  = 1'b0;
        lsu_resp_d  = 1'b0;
        ifu_rdata_d = ifu_rdata_q;
        lsu_rdata_d = lsu_rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (ifu_req_i || lsu_req_i) begin
                    state_d    = ST_ACCESS;
                    cnt_d      = '0;
                    ram_ce_n_d = 1'b0;
                    sel_lsu_d  = w_grant_lsu;
                    if (w_grant_lsu) begin
                        ram_addr_d  = lsu_addr_i[21:2];
                        ram_wdata_d = lsu_wdata_i;
                        ram_be_n_d  = lsu_be_n_i;
                        write_d     = ~lsu_we_n_i;
                        ram_oe_n_d  = ~lsu_we_n_i;
                        ram_we_n_d  = lsu_we_n_i;
                        if (!ifu_req_i) begin
                            starve_d = '0;
                        end else if (starve_q != c_STARVE_MAX) begin
                            starve_d = starve_q + c_STV_W'(1);
                        end
                    end else begin
                        ram_addr_d = ifu_addr_i[21:2];
                        ram_be_n_d = 4'b0000;
                        write_d    = 1'b0;
                        ram_oe_n_d = 1'b0;
                        ram_we_n_d = 1'b1;
                        starve_d   = '0;
                    end
                end
            end

            ST_ACCESS: begin
                if (cnt_q == c_WAIT) begin
                    state_d    = ST_DONE;
                    ram_ce_n_d = 1'b1;
                    ram_oe_n_d = 1'b1;
                    ram_we_n_d = 1'b1;
                    ram_be_n_d = 4'hF;
                    if (sel_lsu_q) begin
                        lsu_rdata_d = ram_rdata_i;
                        lsu_resp_d  = 1'b1;
                    end else begin
                        ifu_rdata_d = ram_rdata_i;
                        ifu_resp_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + c_CNT_W'(1);
                    // Release write enable for the final cycle so data/address hold past WE rise.
                    if (write_q && ((cnt_q + c_CNT_W'(1)) == c_WAIT)) begin
                        ram_we_n_d = 1'b1;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign ifu_resp_o  = ifu_resp_q;
    assign ifu_rdata_o = ifu_rdata_q;
    assign lsu_resp_o  = lsu_resp_q;
    assign lsu_rdata_o = lsu_rdata_q;
    assign ram_addr_o  = ram_addr_q;
    assign ram_wdata_o = ram_wdata_q;
    assign ram_be_n_o  = ram_be_n_q;
    assign ram_ce_n_o  = ram_ce_n_q;
    assign ram_oe_n_o  = ram_oe_n_q;
    assign ram_we_n_o  = ram_we_n_q;
    assign busy_o      = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_base_ram_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_base_ram_sched
// Function : Randomized bench for base_ram_sched with a transaction-level model
//            plus directed literal scenarios.
// Revision : 1.0 - initial release
// ============================================================================
module tb_base_ram_sched;

    localparam int W  = 1;
    localparam int SL = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] ifu_addr_i;
    logic        ifu_req_i;
    logic        ifu_resp_o;
    logic [31:0] ifu_rdata_o;
    logic [31:0] lsu_addr_i;
    logic [31:0] lsu_wdata_i;
    logic [3:0]  lsu_be_n_i;
    logic        lsu_we_n_i;
    logic        lsu_req_i;
    logic        lsu_resp_o;
    logic [31:0] lsu_rdata_o;
    logic [19:0] ram_addr_o;
    logic [31:0] ram_wdata_o;
    logic [31:0] ram_rdata_i;
    logic [3:0]  ram_be_n_o;
    logic        ram_ce_n_o;
    logic        ram_oe_n_o;
    logic        ram_we_n_o;
    logic        busy_o;

    // Second instance with a longer access, driven by its own request lines.
    logic        ifu_req3;
    logic        lsu_req3;
    logic        ifu_resp3;
    logic [31:0] ifu_rdata3;
    logic        lsu_resp3;
    logic [31:0] lsu_rdata3;
    logic [19:0] ram_addr3;
    logic [31:0] ram_wdata3;
    logic [3:0]  ram_be_n3;
    logic        ram_ce_n3;
    logic        ram_oe_n3;
    logic        ram_we_n3;
    logic        busy3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    base_ram_sched #(.WAIT_CYCLES(W), .STARVE_LIMIT(SL)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .ifu_addr_i(ifu_addr_i), .ifu_req_i(ifu_req_i),
        .ifu_resp_o(ifu_resp_o), .ifu_rdata_o(ifu_rdata_o),
        .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i),
        .lsu_be_n_i(lsu_be_n_i), .lsu_we_n_i(lsu_we_n_i), .lsu_req_i(lsu_req_i),
        .lsu_resp_o(lsu_resp_o), .lsu_rdata_o(lsu_rdata_o),
        .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i),
        .ram_be_n_o(ram_be_n_o), .ram_ce_n_o(ram_ce_n_o), .ram_oe_n_o(ram_oe_n_o),
        .ram_we_n_o(ram_we_n_o), .busy_o(busy_o)
    );

    base_ram_sched #(.WAIT_CYCLES(3), .STARVE_LIMIT(SL)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .ifu_addr_i(ifu_addr_i), .ifu_req_i(ifu_req3),
        .ifu_resp_o(ifu_resp3), .ifu_rdata_o(ifu_rdata3),
        .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i),
        .lsu_be_n_i(lsu_be_n_i), .lsu_we_n_i(lsu_we_n_i), .lsu_req_i(lsu_req3),
        .lsu_resp_o(lsu_resp3), .lsu_rdata_o(lsu_rdata3),
        .ram_addr_o(ram_addr3), .ram_wdata_o(ram_wdata3), .ram_rdata_i(ram_rdata_i),
        .ram_be_n_o(ram_be_n3), .ram_ce_n_o(ram_ce_n3), .ram_oe_n_o(ram_oe_n3),
        .ram_we_n_o(ram_we_n3), .busy_o(busy3)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Transaction-level model: each grant at cycle g occupies cycles
    // g+1..g+W+1 on the SRAM and responds at g+W+2.
    // ------------------------------------------------------------------
    int          m_cyc, m_g, m_k, m_starve;
    bit          m_act, m_done_now, m_lsu, m_wr, m_lsu_known, m_lsu_win;
    logic [19:0] m_addr;
    logic [31:0] m_wdata, m_cap, m_ifu_rd, m_lsu_rd;
    logic [3:0]  m_be;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_ce", ram_ce_n_o, 1'b1);
            chk("rst_oe", ram_oe_n_o, 1'b1);
            chk("rst_we", ram_we_n_o, 1'b1);
            chk("rst_be", ram_be_n_o, 4'hF);
            chk("rst_addr", ram_addr_o, 20'h0);
            chk("rst_wdata", ram_wdata_o, 32'h0);
            chk("rst_resp", {ifu_resp_o, lsu_resp_o}, 2'b00);
            chk("rst_rdata", ifu_rdata_o | lsu_rdata_o, 32'h0);
            chk("rst_busy", busy_o, 1'b0);
            m_act = 0; m_starve = 0; m_cyc = 0;
            m_ifu_rd = '0; m_lsu_rd = '0; m_lsu_known = 1;
        end else begin
            m_k = m_act ? (m_cyc - m_g) : 0;
            m_done_now = 0;
            if (m_act && m_k >= 1 && m_k <= W + 1) begin
                chk("acc_ce", ram_ce_n_o, 1'b0);
                chk("acc_oe", ram_oe_n_o, m_wr ? 1'b1 : 1'b0);
                chk("acc_we", ram_we_n_o, (m_wr && m_k <= W) ? 1'b0 : 1'b1);
                chk("acc_addr", ram_addr_o, m_addr);
                chk("acc_be", ram_be_n_o, m_be);
                chk("acc_busy", busy_o, 1'b1);
                chk("acc_resp", {ifu_resp_o, lsu_resp_o}, 2'b00);
                if (m_wr) chk("acc_wdata", ram_wdata_o, m_wdata);
                if (m_k == W + 1) m_cap = ram_rdata_i;
            end else if (m_act && m_k == W + 2) begin
                chk("done_ctl", {ram_ce_n_o, ram_oe_n_o, ram_we_n_o}, 3'b111);
                chk("done_be", ram_be_n_o, 4'hF);
                chk("done_busy", busy_o, 1'b1);
                chk("done_resp", {ifu_resp_o, lsu_resp_o}, m_lsu ? 2'b01 : 2'b10);
                if (m_lsu) begin
                    if (m_wr) m_lsu_known = 0;
                    else begin m_lsu_rd = m_cap; m_lsu_known = 1; end
                end else begin
                    m_ifu_rd = m_cap;
                end
                m_act = 0;
                m_done_now = 1;
            end else begin
                chk("idle_ctl", {ram_ce_n_o, ram_oe_n_o, ram_we_n_o}, 3'b111);
                chk("idle_be", ram_be_n_o, 4'hF);
                chk("idle_busy", busy_o, 1'b0);
                chk("idle_resp", {ifu_resp_o, lsu_resp_o}, 2'b00);
            end
            chk("ifu_rdata", ifu_rdata_o, m_ifu_rd);
            if (m_lsu_known) chk("lsu_rdata", lsu_rdata_o, m_lsu_rd);

            if (!m_act && !m_done_now && (ifu_req_i || lsu_req_i)) begin
                m_lsu_win = lsu_req_i && !(ifu_req_i && m_starve == SL);
                if (m_lsu_win) begin
                    m_starve = ifu_req_i ? ((m_starve < SL) ? m_starve + 1 : SL) : 0;
                    m_lsu = 1; m_wr = ~lsu_we_n_i;
                    m_addr = lsu_addr_i[21:2]; m_wdata = lsu_wdata_i; m_be = lsu_be_n_i;
                end else begin
                    m_starve = 0;
                    m_lsu = 0; m_wr = 0;
                    m_addr = ifu_addr_i[21:2]; m_be = 4'b0000;
                end
                m_act = 1;
                m_g = m_cyc;
            end
            m_cyc++;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    bit ifu_pend, lsu_pend;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step_random(input int p_ifu, input int p_lsu);
        @(negedge clk);
        if (ifu_resp_o) ifu_pend = 1'b0;
        if (lsu_resp_o) lsu_pend = 1'b0;
        tick();
        ram_rdata_i = $urandom;
        if (!ifu_pend) begin
            if (int'($urandom_range(99)) < p_ifu) begin
                ifu_pend = 1'b1; ifu_req_i = 1'b1; ifu_addr_i = $urandom;
            end else begin
                ifu_req_i = 1'b0;
            end
        end
        if (!lsu_pend) begin
            if (int'($urandom_range(99)) < p_lsu) begin
                lsu_pend = 1'b1; lsu_req_i = 1'b1;
                lsu_addr_i = $urandom; lsu_wdata_i = $urandom;
                lsu_be_n_i = 4'($urandom); lsu_we_n_i = 1'($urandom);
            end else begin
                lsu_req_i = 1'b0;
            end
        end
    endtask

    int t_l, t_i, nres;
    bit order [6];
    bit exp_order [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    initial begin
        rst_n = 1'b0;
        ifu_addr_i = '0; ifu_req_i = 1'b0;
        lsu_addr_i = '0; lsu_wdata_i = '0; lsu_be_n_i = 4'hF; lsu_we_n_i = 1'b1; lsu_req_i = 1'b0;
        ram_rdata_i = '0; ifu_req3 = 1'b0; lsu_req3 = 1'b0;
        ifu_pend = 0; lsu_pend = 0;
        @(negedge clk);
        chk("rst3_ce", ram_ce_n3, 1'b1);
        tick();
        rst_n = 1'b1;

        // IFU read of 0x8000_0010
        ifu_addr_i = 32'h8000_0010; ifu_req_i = 1'b1; ram_rdata_i = 32'hDEAD_BEEF;
        tick();
        @(negedge clk);
        chk("t2_addr", ram_addr_o, 20'h4);
        chk("t2_ce1", ram_ce_n_o, 1'b0);
        chk("t2_oe1", ram_oe_n_o, 1'b0);
        chk("t2_be", ram_be_n_o, 4'b0000);
        tick();
        ram_rdata_i = 32'h1234_5678;
        @(negedge clk);
        chk("t2_oe2", ram_oe_n_o, 1'b0);
        chk("t2_noresp2", ifu_resp_o, 1'b0);
        tick();
        ram_rdata_i = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("t2_resp3", ifu_resp_o, 1'b1);
        chk("t2_rdata", ifu_rdata_o, 32'h1234_5678);
        tick();
        ifu_req_i = 1'b0;

        // LSU write of 0x8000_0020
        lsu_addr_i = 32'h8000_0020; lsu_wdata_i = 32'hCAFE_F00D; lsu_be_n_i = 4'b1100;
        lsu_we_n_i = 1'b0; lsu_req_i = 1'b1;
        tick();
        @(negedge clk);
        chk("t3_we1", ram_we_n_o, 1'b0);
        chk("t3_addr", ram_addr_o, 20'h8);
        chk("t3_wdata1", ram_wdata_o, 32'hCAFE_F00D);
        chk("t3_be1", ram_be_n_o, 4'b1100);
        tick();
        @(negedge clk);
        chk("t3_we2", ram_we_n_o, 1'b1);
        chk("t3_ce2", ram_ce_n_o, 1'b0);
        chk("t3_wdata2", ram_wdata_o, 32'hCAFE_F00D);
        chk("t3_be2", ram_be_n_o, 4'b1100);
        tick();
        @(negedge clk);
        chk("t3_resp", lsu_resp_o, 1'b1);
        tick();
        lsu_req_i = 1'b0;

        // Simultaneous requests
        ifu_addr_i = 32'h8000_0100; ifu_req_i = 1'b1;
        lsu_addr_i = 32'h8000_0200; lsu_we_n_i = 1'b1; lsu_be_n_i = 4'b0000; lsu_req_i = 1'b1;
        t_l = -1; t_i = -1;
        for (int n = 0; n < 40 && (t_l < 0 || t_i < 0); n++) begin
            @(negedge clk);
            if (lsu_resp_o && t_l < 0) t_l = n;
            if (ifu_resp_o && t_i < 0) t_i = n;
            tick();
            if (t_l >= 0) lsu_req_i = 1'b0;
            if (t_i >= 0) ifu_req_i = 1'b0;
        end
        chk("t4_lsu_lat", t_l, 32'd3);
        chk("t4_gap", t_i - t_l, 32'd4);

        // Starvation: LSU re-requests continuously while IFU waits
        lsu_addr_i = 32'h8000_0300; lsu_we_n_i = 1'b1; lsu_be_n_i = 4'b0000; lsu_req_i = 1'b1;
        ifu_addr_i = 32'h8000_0400; ifu_req_i = 1'b1;
        nres = 0;
        for (int n = 0; n < 200 && nres < 6; n++) begin
            @(negedge clk);
            if (lsu_resp_o) begin order[nres] = 1'b1; nres++; end
            else if (ifu_resp_o) begin order[nres] = 1'b0; nres++; end
            tick();
        end
        ifu_req_i = 1'b0; lsu_req_i = 1'b0;
        chk("t5_count", nres, 32'd6);
        for (int i = 0; i < 6; i++) chk($sformatf("t5_grant%0d", i), order[i], exp_order[i]);

        // Randomized traffic
        for (int n = 0; n < 300; n++) step_random(50, 50);
        for (int n = 0; n < 150; n++) step_random(100, 100);
        for (int n = 0; n < 300; n++) step_random(30, 70);
        for (int n = 0; n < 60 && (ifu_pend || lsu_pend); n++) step_random(0, 0);
        chk("drain", {ifu_pend, lsu_pend}, 2'b00);

        // Reset in the middle of an LSU write
        lsu_addr_i = 32'h8000_0500; lsu_wdata_i = 32'h0BAD_F00D; lsu_be_n_i = 4'b0000;
        lsu_we_n_i = 1'b0; lsu_req_i = 1'b1;
        tick();
        #2;
        rst_n = 1'b0;
        lsu_req_i = 1'b0;
        #1;
        chk("t1_ce", ram_ce_n_o, 1'b1);
        chk("t1_we", ram_we_n_o, 1'b1);
        chk("t1_busy", busy_o, 1'b0);
        tick();
        rst_n = 1'b1;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            chk("t1_noresp", lsu_resp_o, 1'b0);
            tick();
        end

        // Long access on the WAIT_CYCLES=3 instance
        ifu_addr_i = 32'h0000_0040; ifu_req3 = 1'b1; ram_rdata_i = 32'hA5A5_0000;
        for (int k = 1; k <= 5; k++) begin
            tick();
            ram_rdata_i = 32'hA5A5_0000 + 32'(k);
            @(negedge clk);
            chk($sformatf("t6_ce%0d", k), ram_ce_n3, (k <= 4) ? 1'b0 : 1'b1);
            chk($sformatf("t6_resp%0d", k), ifu_resp3, (k == 5) ? 1'b1 : 1'b0);
            if (k == 1) chk("t6_addr", ram_addr3, 20'h10);
        end
        chk("t6_rdata", ifu_rdata3, 32'hA5A5_0004);
        tick();
        ifu_req3 = 1'b0;
        repeat (2) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
